reg_write_arbiter: RTL and testbench

- Shares the single write port of the 4-entry, 4-bit general register bank between three requesters: instruction execute, memory load return, and debug/monitor port.
- Arbitrates round-robin and latches the winning address/data.
- Drives each register's DATA_WRITE enable as a one-cycle pulse, plus the common DATA_IN bus.
- Completes a four-phase REQ/GNT handshake with the winner.

---
 rtl/reg_write_arbiter.sv | 114 +++++++++++
 tb/tb_reg_write_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of the register bank's single write port: three REQ/GNT requesters,
// the winner's address/data latched and applied as a one-cycle WR_EN pulse.
module reg_write_arbiter #(
    parameter int DATA_W  = 4,
    parameter int NREG    = 4,
    parameter int NUM_REQ = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [1:0]         REQ_ADDR0,
    input  logic [1:0]         REQ_ADDR1,
    input  logic [1:0]         REQ_ADDR2,
    input  logic [DATA_W-1:0]  REQ_DATA0,
    input  logic [DATA_W-1:0]  REQ_DATA1,
    input  logic [DATA_W-1:0]  REQ_DATA2,
    output logic [NUM_REQ-1:0] GNT,
    output logic [NREG-1:0]    WR_EN,
    output logic [DATA_W-1:0]  WR_DATA,
    output logic               BUSY,
    output logic [1:0]         LAST_WIN,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        ptr;
    logic [1:0]        win;
    logic [1:0]        pick;
    logic [1:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        ptr_next;

    // First requester at or after ptr, wrapping 2 -> 0; only meaningful when REQ != 0.
    always_comb begin
        pick = 2'd0;
        case (ptr)
            2'd0:    pick = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
            2'd1:    pick = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
            default: pick = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
        endcase
    end

    always_comb begin
        sel_addr = REQ_ADDR0;
        sel_data = REQ_DATA0;
        case (pick)
            2'd1: begin
                sel_addr = REQ_ADDR1;
                sel_data = REQ_DATA1;
            end
            2'd2: begin
                sel_addr = REQ_ADDR2;
                sel_data = REQ_DATA2;
            end
            default: begin
                sel_addr = REQ_ADDR0;
                sel_data = REQ_DATA0;
            end
        endcase
    end

    assign ptr_next  = (win == 2'd2) ? 2'd0 : win + 2'd1;
    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

    // Handshake: a requester holds REQ/ADDR/DATA until it sees GNT high, then drops REQ
    // and may re-raise only after seeing GNT low; GNT falls on the edge sampling REQ[win]=0.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            win      <= 2'd0;
            GNT      <= '0;
            WR_EN    <= '0;
            WR_DATA  <= '0;
            LAST_WIN <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (|REQ) begin
                        state   <= WRITE;
                        win     <= pick;
                        GNT     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        WR_EN   <= {{(NREG-1){1'b0}}, 1'b1} << sel_addr;
                        WR_DATA <= sel_data;
                    end
                end
                WRITE: begin
                    // The register loads on this edge; the pointer advances past the winner.
                    state    <= RELEASE;
                    ptr      <= ptr_next;
                    LAST_WIN <= win;
                    WR_EN    <= '0;
                end
                RELEASE: begin
                    if (!REQ[win]) begin
                        state <= IDLE;
                        GNT   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    GNT   <= '0;
                    WR_EN <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table, directed handshake sequences,
// and randomized four-phase requesters scored against a transaction-level round-robin model.
module tb_reg_write_arbiter;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [2:0] REQ = 3'b000;
    logic [1:0] REQ_ADDR0 = 2'd0, REQ_ADDR1 = 2'd0, REQ_ADDR2 = 2'd0;
    logic [3:0] REQ_DATA0 = 4'h0, REQ_DATA1 = 4'h0, REQ_DATA2 = 4'h0;
    logic [2:0] GNT;
    logic [3:0] WR_EN;
    logic [3:0] WR_DATA;
    logic       BUSY;
    logic [1:0] LAST_WIN;
    logic [1:0] dbg_state;

    int passed = 0;
    int total  = 0;

    // Register bank contents as seen by the bank: loads WR_DATA where WR_EN is set.
    logic [3:0] bank [4] = '{default: 4'h0};
    logic [5:0] exp_q[$];

    typedef struct {
        logic [2:0] req;
        logic [1:0] addr;
        logic [3:0] data;
        logic [2:0] gnt;
        logic [3:0] wr_en;
        logic [1:0] lw_before;
        logic [1:0] lw_after;
        int         hold;
    } vec_t;
    vec_t vecs[5];

    // Random-phase model state
    logic [2:0] sreq, prev_gnt, g;
    logic [3:0] e4;
    logic [5:0] ent;
    int         age, mptr, cur_w;
    logic [1:0] mlast;
    logic [3:0] mdata;
    int         waits[3];
    bit         pend[3], need_low[3];
    int         dly[3];
    logic [1:0] ra[3];
    logic [3:0] rd[3];
    logic [3:0] exp_bank[4];

    reg_write_arbiter #(.DATA_W(4), .NREG(4), .NUM_REQ(3)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .REQ       (REQ),
        .REQ_ADDR0 (REQ_ADDR0),
        .REQ_ADDR1 (REQ_ADDR1),
        .REQ_ADDR2 (REQ_ADDR2),
        .REQ_DATA0 (REQ_DATA0),
        .REQ_DATA1 (REQ_DATA1),
        .REQ_DATA2 (REQ_DATA2),
        .GNT       (GNT),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .BUSY      (BUSY),
        .LAST_WIN  (LAST_WIN),
        .dbg_state (dbg_state)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) begin
        for (int i = 0; i < 4; i++)
            if (WR_EN[i]) bank[i] <= WR_DATA;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        REQ   = 3'b000;
        RESET = 1'b0;
        step();
        step();
        RESET = 1'b1;
    endtask

    function automatic int rr_pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return 0;
    endfunction

    // Caller has driven REQ with requester w pending and the arbiter idle.
    task automatic serve(input int w, input logic [1:0] addr, input logic [3:0] data,
                         input logic [1:0] lw_before, input bit early, input int hold);
        logic [2:0] gx;
        logic [3:0] ex;
        gx = 3'b001 << w;
        ex = 4'b0001 << addr;
        step();
        check("grant", 8'(GNT), 8'(gx));
        check("wr_en_pulse", 8'(WR_EN), 8'(ex));
        check("wr_data", 8'(WR_DATA), 8'(data));
        check("busy_write", 8'(BUSY), 8'd1);
        check("last_win_write", 8'(LAST_WIN), 8'(lw_before));
        if (early) REQ[w] = 1'b0;
        step();
        check("gnt_release", 8'(GNT), 8'(gx));
        check("wr_en_off", 8'(WR_EN), 8'd0);
        check("wr_data_hold", 8'(WR_DATA), 8'(data));
        check("last_win_release", 8'(LAST_WIN), 8'(w));
        check("bank_written", 8'(bank[addr]), 8'(data));
        for (int i = 0; i < hold; i++) begin
            step();
            check("gnt_hold", 8'(GNT), 8'(gx));
        end
        REQ[w] = 1'b0;
        step();
        check("gnt_drop", 8'(GNT), 8'd0);
        check("busy_idle", 8'(BUSY), 8'd0);
    endtask

    initial begin
        vecs[0] = '{3'b010, 2'd3, 4'h5, 3'b010, 4'b1000, 2'd2, 2'd1, 2};
        vecs[1] = '{3'b001, 2'd0, 4'hA, 3'b001, 4'b0001, 2'd1, 2'd0, 0};
        vecs[2] = '{3'b100, 2'd2, 4'hF, 3'b100, 4'b0100, 2'd0, 2'd2, 1};
        vecs[3] = '{3'b100, 2'd1, 4'h0, 3'b100, 4'b0010, 2'd2, 2'd2, 0};
        vecs[4] = '{3'b001, 2'd3, 4'h9, 3'b001, 4'b1000, 2'd2, 2'd0, 0};

        // Reset values, then a write aborted by reset in its WRITE cycle.
        do_reset();
        check("rst_gnt", 8'(GNT), 8'd0);
        check("rst_wr_en", 8'(WR_EN), 8'd0);
        check("rst_wr_data", 8'(WR_DATA), 8'd0);
        check("rst_busy", 8'(BUSY), 8'd0);
        check("rst_last_win", 8'(LAST_WIN), 8'd3);
        REQ_ADDR0 = 2'd2; REQ_DATA0 = 4'hA; REQ = 3'b001;
        step();
        check("abort_gnt", 8'(GNT), 8'b001);
        check("abort_wr_en", 8'(WR_EN), 8'b0100);
        #2 RESET = 1'b0;
        #1;
        check("async_gnt", 8'(GNT), 8'd0);
        check("async_wr_en", 8'(WR_EN), 8'd0);
        check("async_busy", 8'(BUSY), 8'd0);
        check("async_last_win", 8'(LAST_WIN), 8'd3);
        step();
        check("rst_hold_gnt", 8'(GNT), 8'd0);
        check("rst_hold_wr_en", 8'(WR_EN), 8'd0);
        check("aborted_not_written", 8'(bank[2]), 8'd0);
        REQ = 3'b000;
        RESET = 1'b1;
        step();
        REQ_ADDR0 = 2'd2; REQ_DATA0 = 4'hA;
        REQ_ADDR2 = 2'd0; REQ_DATA2 = 4'h6;
        REQ = 3'b101;
        serve(0, 2'd2, 4'hA, 2'd3, 1'b0, 0);
        serve(2, 2'd0, 4'h6, 2'd0, 1'b0, 0);

        // Contention rotation with early drops, then pointer wrap.
        do_reset();
        REQ_ADDR0 = 2'd0; REQ_DATA0 = 4'h1;
        REQ_ADDR1 = 2'd1; REQ_DATA1 = 4'h2;
        REQ_ADDR2 = 2'd2; REQ_DATA2 = 4'h3;
        REQ = 3'b111;
        serve(0, 2'd0, 4'h1, 2'd3, 1'b1, 0);
        REQ[0] = 1'b1;
        serve(1, 2'd1, 4'h2, 2'd0, 1'b1, 0);
        REQ[1] = 1'b1;
        serve(2, 2'd2, 4'h3, 2'd1, 1'b1, 0);
        REQ[2] = 1'b1;
        serve(0, 2'd0, 4'h1, 2'd2, 1'b1, 0);
        serve(1, 2'd1, 4'h2, 2'd0, 1'b0, 0);
        REQ[0] = 1'b1;
        check("wrap_req", 8'(REQ), 8'b101);
        serve(2, 2'd2, 4'h3, 2'd1, 1'b0, 0);
        serve(0, 2'd0, 4'h1, 2'd2, 1'b0, 0);

        // Same-register writes land in grant order.
        do_reset();
        REQ_ADDR0 = 2'd1; REQ_DATA0 = 4'h3;
        REQ_ADDR2 = 2'd1; REQ_DATA2 = 4'hC;
        REQ = 3'b101;
        serve(0, 2'd1, 4'h3, 2'd3, 1'b0, 1);
        serve(2, 2'd1, 4'hC, 2'd0, 1'b0, 0);
        check("same_reg_final", 8'(bank[1]), 8'hC);

        // Table-driven single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            REQ_ADDR0 = vecs[v].req[0] ? vecs[v].addr : ~vecs[v].addr;
            REQ_ADDR1 = vecs[v].req[1] ? vecs[v].addr : ~vecs[v].addr;
            REQ_ADDR2 = vecs[v].req[2] ? vecs[v].addr : ~vecs[v].addr;
            REQ_DATA0 = vecs[v].req[0] ? vecs[v].data : ~vecs[v].data;
            REQ_DATA1 = vecs[v].req[1] ? vecs[v].data : ~vecs[v].data;
            REQ_DATA2 = vecs[v].req[2] ? vecs[v].data : ~vecs[v].data;
            REQ = vecs[v].req;
            step();
            check("vec_gnt", 8'(GNT), 8'(vecs[v].gnt));
            check("vec_wr_en", 8'(WR_EN), 8'(vecs[v].wr_en));
            check("vec_wr_data", 8'(WR_DATA), 8'(vecs[v].data));
            check("vec_busy", 8'(BUSY), 8'd1);
            check("vec_lw_before", 8'(LAST_WIN), 8'(vecs[v].lw_before));
            step();
            check("vec_release_gnt", 8'(GNT), 8'(vecs[v].gnt));
            check("vec_wr_en_off", 8'(WR_EN), 8'd0);
            check("vec_lw_after", 8'(LAST_WIN), 8'(vecs[v].lw_after));
            for (int i = 0; i < vecs[v].hold; i++) begin
                step();
                check("vec_gnt_hold", 8'(GNT), 8'(vecs[v].gnt));
            end
            REQ = 3'b000;
            step();
            check("vec_gnt_drop", 8'(GNT), 8'd0);
            check("vec_busy_idle", 8'(BUSY), 8'd0);
            check("vec_bank", 8'(bank[vecs[v].addr]), 8'(vecs[v].data));
        end

        // Randomized four-phase requesters against the round-robin transaction model.
        do_reset();
        mptr = 0; mlast = 2'd3; mdata = 4'h0; prev_gnt = 3'b000; age = 0; cur_w = 0;
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; need_low[i] = 1'b0; waits[i] = 0; dly[i] = 0;
            ra[i] = 2'd0; rd[i] = 4'h0;
        end
        for (int i = 0; i < 4; i++) exp_bank[i] = bank[i];
        for (int cyc = 0; cyc < 1540; cyc++) begin
            step();
            sreq = REQ;
            check("rnd_busy", 8'(BUSY), 8'(GNT != 3'b000));
            if (prev_gnt == 3'b000) begin
                if (sreq != 3'b000) begin
                    cur_w = rr_pick(sreq, mptr);
                    g  = 3'b001 << cur_w;
                    e4 = 4'b0001 << ra[cur_w];
                    check("rnd_grant", 8'(GNT), 8'(g));
                    check("rnd_wr_en", 8'(WR_EN), 8'(e4));
                    check("rnd_wr_data", 8'(WR_DATA), 8'(rd[cur_w]));
                    check("rnd_lw_write", 8'(LAST_WIN), 8'(mlast));
                    exp_q.push_back({ra[cur_w], rd[cur_w]});
                    exp_bank[ra[cur_w]] = rd[cur_w];
                    mdata = rd[cur_w];
                    mlast = 2'(cur_w);
                    mptr  = (cur_w + 1) % 3;
                    for (int j = 0; j < 3; j++) begin
                        if (j != cur_w && sreq[j]) begin
                            waits[j]++;
                            check("rnd_fair_wait", 8'(waits[j] <= 2), 8'd1);
                        end
                    end
                    waits[cur_w] = 0;
                    age = 1;
                end else begin
                    check("rnd_idle_gnt", 8'(GNT), 8'd0);
                    check("rnd_idle_wr_en", 8'(WR_EN), 8'd0);
                    check("rnd_idle_wr_data", 8'(WR_DATA), 8'(mdata));
                    check("rnd_idle_lw", 8'(LAST_WIN), 8'(mlast));
                end
            end else begin
                age++;
                check("rnd_wr_en_off", 8'(WR_EN), 8'd0);
                check("rnd_data_hold", 8'(WR_DATA), 8'(mdata));
                check("rnd_lw", 8'(LAST_WIN), 8'(mlast));
                if (age == 2) begin
                    check("rnd_release_gnt", 8'(GNT), 8'(prev_gnt));
                    check("rnd_q_size", 8'(exp_q.size()), 8'd1);
                    if (exp_q.size() > 0) begin
                        ent = exp_q.pop_front();
                        check("rnd_bank", 8'(bank[ent[5:4]]), 8'(ent[3:0]));
                    end
                end else begin
                    check("rnd_release_exit", 8'(GNT), 8'(sreq[cur_w] ? prev_gnt : 3'b000));
                end
            end
            prev_gnt = GNT;

            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    if (GNT[i]) begin
                        if (dly[i] == 0) begin
                            pend[i] = 1'b0;
                            need_low[i] = 1'b1;
                        end else begin
                            dly[i]--;
                        end
                    end
                end else if (need_low[i]) begin
                    if (!GNT[i]) need_low[i] = 1'b0;
                end
                if (!pend[i] && !need_low[i] && cyc < 1500 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i]   = 2'($urandom_range(0, 3));
                    rd[i]   = 4'($urandom_range(0, 15));
                    dly[i]  = $urandom_range(0, 2);
                end else if (!pend[i]) begin
                    ra[i] = 2'($urandom_range(0, 3));
                    rd[i] = 4'($urandom_range(0, 15));
                end
            end
            REQ = {pend[2], pend[1], pend[0]};
            REQ_ADDR0 = ra[0]; REQ_DATA0 = rd[0];
            REQ_ADDR1 = ra[1]; REQ_DATA1 = rd[1];
            REQ_ADDR2 = ra[2]; REQ_DATA2 = rd[2];
        end
        check("rnd_drained_q", 8'(exp_q.size()), 8'd0);
        check("rnd_drained_gnt", 8'(GNT), 8'd0);
        for (int i = 0; i < 4; i++)
            check("rnd_final_bank", 8'(bank[i]), 8'(exp_bank[i]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
